// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter serving LSB loads/stores and 4-byte instruction fetches.
// Define MEMCTRL_IO_GUARD_EN to throttle stores into the IO region on io_buffer_full.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req_flag,
  input  logic [31:0] if_req_addr,
  output logic        if_done_flag,
  output logic [31:0] if_done_inst,
  input  logic        jump_wrong_stall,
  input  logic        lsb_req_flag,
  input  logic [1:0]  lsb_req_width,
  input  logic        lsb_req_type,
  input  logic        lsb_req_sext,
  input  logic [31:0] lsb_req_addr,
  input  logic [31:0] lsb_req_data,
  input  logic [31:0] lsb_req_rob_id,
  output logic        lsb_done_flag,
  output logic        ld_cdb_flag,
  output logic [31:0] ld_cdb_rob_id,
  output logic [31:0] ld_cdb_val
);

  typedef enum logic [2:0] {StIdle, StIfRd, StLsRd, StLsWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  width_q, width_d;
  logic        sext_q, sext_d;
  logic [31:0] rob_q, rob_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        lsb_done_q, lsb_done_d;
  logic        cdb_flag_q, cdb_flag_d;
  logic [31:0] cdb_rob_q, cdb_rob_d;
  logic [31:0] cdb_val_q, cdb_val_d;

`ifdef MEMCTRL_IO_GUARD_EN
  logic        io_q, io_d;
`else
  logic        unused_io;
  assign unused_io = ^{io_buffer_full, IO_BASE};
`endif

  logic [1:0]  rd_idx, wr_idx;
  logic [31:0] asm_word, ld_ext, next_addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    width_d    = width_q;
    sext_d     = sext_q;
    rob_d      = rob_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_inst_d  = if_inst_q;
    cdb_rob_d  = cdb_rob_q;
    cdb_val_d  = cdb_val_q;
    if_done_d  = 1'b0;
    lsb_done_d = 1'b0;
    cdb_flag_d = 1'b0;
`ifdef MEMCTRL_IO_GUARD_EN
    io_d       = io_q;
`endif

    // mem_din carries the byte addressed one cycle earlier, i.e. byte cnt-1
    rd_idx    = cnt_q[1:0] - 2'd1;
    wr_idx    = cnt_q[1:0] + 2'd1;
    next_addr = addr_q + {29'd0, cnt_q} + 32'd1;
    asm_word  = buf_q;
    asm_word[{rd_idx, 3'b000} +: 8] = mem_din;

    case (width_q)
      2'b00:   ld_ext = sext_q ? {{24{asm_word[7]}}, asm_word[7:0]} : {24'd0, asm_word[7:0]};
      2'b01:   ld_ext = sext_q ? {{16{asm_word[15]}}, asm_word[15:0]} : {16'd0, asm_word[15:0]};
      default: ld_ext = asm_word;
    endcase

    case (state_q)
      StIdle: begin
        if (lsb_req_flag) begin
          addr_d   = lsb_req_addr;
          data_d   = lsb_req_data;
          width_d  = lsb_req_width;
          sext_d   = lsb_req_sext;
          rob_d    = lsb_req_rob_id;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          mem_a_d  = lsb_req_addr;
          mem_wr_d = 1'b0;
          case (lsb_req_width)
            2'b00:   len_d = 3'd1;
            2'b01:   len_d = 3'd2;
            default: len_d = 3'd4;
          endcase
          if (lsb_req_type) begin
            state_d    = StLsWr;
            mem_dout_d = lsb_req_data[7:0];
            mem_wr_d   = 1'b1;
`ifdef MEMCTRL_IO_GUARD_EN
            io_d = (lsb_req_addr >= IO_BASE);
            if (io_d) mem_wr_d = 1'b0;
`endif
          end else begin
            state_d = StLsRd;
          end
        end else if (if_req_flag && !jump_wrong_stall) begin
          addr_d   = if_req_addr;
          width_d  = 2'b11;
          cnt_d    = 3'd0;
          len_d    = 3'd4;
          buf_d    = 32'd0;
          mem_a_d  = if_req_addr;
          mem_wr_d = 1'b0;
          state_d  = StIfRd;
        end
      end

      StIfRd, StLsRd: begin
        if (state_q == StIfRd && jump_wrong_stall) begin
          state_d = StIdle;
        end else begin
          if (cnt_q != 3'd0) buf_d = asm_word;
          if (cnt_q == len_q) begin
            state_d = StDone;
            if (state_q == StIfRd) begin
              if_done_d = 1'b1;
              if_inst_d = asm_word;
            end else begin
              lsb_done_d = 1'b1;
              cdb_flag_d = !jump_wrong_stall;
              cdb_rob_d  = rob_q;
              cdb_val_d  = ld_ext;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < len_q) mem_a_d = next_addr;
          end
        end
      end

      StLsWr: begin
`ifdef MEMCTRL_IO_GUARD_EN
        // IO stores: wait for buffer space before each byte, one idle cycle after it
        if (io_q) begin
          if (mem_wr_q) begin
            mem_wr_d = 1'b0;
            cnt_d    = cnt_q + 3'd1;
          end else if (cnt_q == len_q) begin
            state_d    = StDone;
            lsb_done_d = 1'b1;
          end else if (!io_buffer_full) begin
            mem_wr_d   = 1'b1;
            mem_a_d    = addr_q + {29'd0, cnt_q};
            mem_dout_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
          end
        end else
`endif
        begin
          if (cnt_q + 3'd1 < len_q) begin
            cnt_d      = cnt_q + 3'd1;
            mem_a_d    = next_addr;
            mem_dout_d = data_q[{wr_idx, 3'b000} +: 8];
          end else begin
            mem_wr_d   = 1'b0;
            state_d    = StDone;
            lsb_done_d = 1'b1;
          end
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      width_q    <= 2'b00;
      sext_q     <= 1'b0;
      rob_q      <= 32'd0;
      buf_q      <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      lsb_done_q <= 1'b0;
      cdb_flag_q <= 1'b0;
      cdb_rob_q  <= 32'd0;
      cdb_val_q  <= 32'd0;
`ifdef MEMCTRL_IO_GUARD_EN
      io_q       <= 1'b0;
`endif
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      width_q    <= width_d;
      sext_q     <= sext_d;
      rob_q      <= rob_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_inst_q  <= if_inst_d;
      lsb_done_q <= lsb_done_d;
      cdb_flag_q <= cdb_flag_d;
      cdb_rob_q  <= cdb_rob_d;
      cdb_val_q  <= cdb_val_d;
`ifdef MEMCTRL_IO_GUARD_EN
      io_q       <= io_d;
`endif
    end
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q;
  assign if_done_flag  = if_done_q;
  assign if_done_inst  = if_inst_q;
  assign lsb_done_flag = lsb_done_q;
  assign ld_cdb_flag   = cdb_flag_q;
  assign ld_cdb_rob_id = cdb_rob_q;
  assign ld_cdb_val    = cdb_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM model with one-cycle read latency plus
// a scoreboard of expected load/fetch results popped when the done pulses appear.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req_flag = 1'b0;
  logic [31:0] if_req_addr = 32'd0;
  logic        if_done_flag;
  logic [31:0] if_done_inst;
  logic        jump_wrong_stall = 1'b0;
  logic        lsb_req_flag = 1'b0;
  logic [1:0]  lsb_req_width = 2'b00;
  logic        lsb_req_type = 1'b0;
  logic        lsb_req_sext = 1'b0;
  logic [31:0] lsb_req_addr = 32'd0;
  logic [31:0] lsb_req_data = 32'd0;
  logic [31:0] lsb_req_rob_id = 32'd0;
  logic        lsb_done_flag;
  logic        ld_cdb_flag;
  logic [31:0] ld_cdb_rob_id;
  logic [31:0] ld_cdb_val;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] val;
  } ld_exp_t;

  ld_exp_t     ld_q[$];
  logic [31:0] if_q[$];
  logic [7:0]  init_mem [0:4095];
  int          n_vec = 0;
  int          n_bad = 0;

  mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr),
    .io_buffer_full   (io_buffer_full),
    .if_req_flag      (if_req_flag),
    .if_req_addr      (if_req_addr),
    .if_done_flag     (if_done_flag),
    .if_done_inst     (if_done_inst),
    .jump_wrong_stall (jump_wrong_stall),
    .lsb_req_flag     (lsb_req_flag),
    .lsb_req_width    (lsb_req_width),
    .lsb_req_type     (lsb_req_type),
    .lsb_req_sext     (lsb_req_sext),
    .lsb_req_addr     (lsb_req_addr),
    .lsb_req_data     (lsb_req_data),
    .lsb_req_rob_id   (lsb_req_rob_id),
    .lsb_done_flag    (lsb_done_flag),
    .ld_cdb_flag      (ld_cdb_flag),
    .ld_cdb_rob_id    (ld_cdb_rob_id),
    .ld_cdb_val       (ld_cdb_val)
  );

  always #5 clk = ~clk;

  // RAM read data is valid the cycle after its address; frozen with rdy like the DUT
  always @(posedge clk) begin
    if (rdy) mem_din <= init_mem[mem_a[11:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    n_vec++;
    if ({mem_wr, lsb_done_flag, ld_cdb_flag, if_done_flag} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000",
               {mem_wr, lsb_done_flag, ld_cdb_flag, if_done_flag});
    end
    n_vec++;
    if (mem_a !== 32'd0) begin
      n_bad++; $display("FAIL reset_mem_a got %h want 0", mem_a);
    end
    n_vec++;
    if (mem_dout !== 8'd0) begin
      n_bad++; $display("FAIL reset_mem_dout got %h want 0", mem_dout);
    end
    n_vec++;
    if ({if_done_inst, ld_cdb_rob_id, ld_cdb_val} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data got %h %h %h want 0", if_done_inst, ld_cdb_rob_id, ld_cdb_val);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_load(input string nm, input logic [31:0] addr, input logic [1:0] w,
                           input logic sx, input logic [31:0] tag, input logic [31:0] val);
    int      n;
    ld_exp_t e;
    logic [31:0] ea;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    e.tag = tag;
    e.val = val;
    ld_q.push_back(e);
    lsb_req_flag   = 1'b1;
    lsb_req_width  = w;
    lsb_req_type   = 1'b0;
    lsb_req_sext   = sx;
    lsb_req_addr   = addr;
    lsb_req_rob_id = tag;
    for (int c = 1; c <= n + 3; c++) begin
      step();
      lsb_req_flag = 1'b0;
      if (c <= n) begin
        ea = addr + 32'(c - 1);
        n_vec++;
        if ({mem_wr, mem_a} !== {1'b0, ea}) begin
          n_bad++;
          $display("FAIL %s addr c%0d got wr=%b a=%h want wr=0 a=%h", nm, c, mem_wr, mem_a, ea);
        end
      end
      if (c == n + 2) begin
        n_vec++;
        if ({lsb_done_flag, ld_cdb_flag} !== 2'b11) begin
          n_bad++;
          $display("FAIL %s done c%0d got %b%b want 11", nm, c, lsb_done_flag, ld_cdb_flag);
        end
        n_vec++;
        if (ld_q.size() == 0) begin
          n_bad++; $display("FAIL %s scoreboard empty", nm);
        end else begin
          e = ld_q.pop_front();
          if ({ld_cdb_rob_id, ld_cdb_val} !== {e.tag, e.val}) begin
            n_bad++;
            $display("FAIL %s cdb got tag=%h val=%h want tag=%h val=%h", nm, ld_cdb_rob_id,
                     ld_cdb_val, e.tag, e.val);
          end
        end
      end else begin
        n_vec++;
        if ({lsb_done_flag, ld_cdb_flag} !== 2'b00) begin
          n_bad++;
          $display("FAIL %s stray_done c%0d got %b%b want 00", nm, c, lsb_done_flag, ld_cdb_flag);
        end
      end
    end
  endtask

  task automatic test_store(input string nm, input logic [31:0] addr, input logic [1:0] w,
                            input logic [31:0] data, input int frz);
    int n;
    logic [31:0] ea;
    logic [7:0]  ed;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    lsb_req_flag   = 1'b1;
    lsb_req_width  = w;
    lsb_req_type   = 1'b1;
    lsb_req_sext   = 1'b0;
    lsb_req_addr   = addr;
    lsb_req_data   = data;
    lsb_req_rob_id = 32'h33;
    for (int c = 1; c <= n + 2; c++) begin
      step();
      lsb_req_flag = 1'b0;
      ea = addr + 32'(c - 1);
      ed = 8'(data >> (8 * (c - 1)));
      if (c <= n) begin
        n_vec++;
        if ({mem_wr, mem_a, mem_dout, lsb_done_flag} !== {1'b1, ea, ed, 1'b0}) begin
          n_bad++;
          $display("FAIL %s wr c%0d got wr=%b a=%h d=%h done=%b want 1 %h %h 0", nm, c, mem_wr,
                   mem_a, mem_dout, lsb_done_flag, ea, ed);
        end
      end else if (c == n + 1) begin
        n_vec++;
        if ({lsb_done_flag, ld_cdb_flag, mem_wr} !== 3'b100) begin
          n_bad++;
          $display("FAIL %s done c%0d got done/cdb/wr=%b%b%b want 100", nm, c, lsb_done_flag,
                   ld_cdb_flag, mem_wr);
        end
      end else begin
        n_vec++;
        if ({lsb_done_flag, mem_wr} !== 2'b00) begin
          n_bad++;
          $display("FAIL %s after c%0d got done/wr=%b%b want 00", nm, c, lsb_done_flag, mem_wr);
        end
      end
      if (c == frz) begin
        rdy = 1'b0;
        repeat (3) begin
          step();
          n_vec++;
          if ({mem_wr, mem_a, mem_dout} !== {1'b1, ea, ed}) begin
            n_bad++;
            $display("FAIL %s freeze got wr=%b a=%h d=%h want 1 %h %h", nm, mem_wr, mem_a,
                     mem_dout, ea, ed);
          end
        end
        rdy = 1'b1;
      end
    end
  endtask

  task automatic test_priority();
    ld_exp_t e;
    ld_q.push_back('{tag: 32'h7, val: 32'h0000_0080});
    if_q.push_back(32'h00A0_0513);
    lsb_req_flag   = 1'b1;
    lsb_req_width  = 2'b00;
    lsb_req_type   = 1'b0;
    lsb_req_sext   = 1'b0;
    lsb_req_addr   = 32'h200;
    lsb_req_rob_id = 32'h7;
    if_req_flag    = 1'b1;
    if_req_addr    = 32'h400;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) begin
        n_vec++;
        if (mem_a !== 32'h200) begin
          n_bad++; $display("FAIL prio_first got a=%h want 00000200", mem_a);
        end
      end
      if (c >= 5 && c <= 8) begin
        n_vec++;
        if (mem_a !== 32'h400 + 32'(c - 5)) begin
          n_bad++; $display("FAIL prio_fetch_addr c%0d got %h want %h", c, mem_a, 32'h400 + c - 5);
        end
      end
      if (c == 3) begin
        n_vec++;
        if ({lsb_done_flag, ld_cdb_flag, if_done_flag} !== 3'b110 || ld_q.size() == 0) begin
          n_bad++;
          $display("FAIL prio_ld_done got %b%b%b want 110", lsb_done_flag, ld_cdb_flag,
                   if_done_flag);
        end else begin
          e = ld_q.pop_front();
          n_vec++;
          if (ld_cdb_val !== e.val || ld_cdb_rob_id !== e.tag) begin
            n_bad++;
            $display("FAIL prio_ld_val got %h/%h want %h/%h", ld_cdb_rob_id, ld_cdb_val, e.tag,
                     e.val);
          end
        end
        lsb_req_flag = 1'b0;
      end else if (c == 10) begin
        n_vec++;
        if (if_done_flag !== 1'b1 || if_q.size() == 0) begin
          n_bad++; $display("FAIL prio_if_done got %b want 1", if_done_flag);
        end else if (if_done_inst !== if_q[0]) begin
          n_bad++; $display("FAIL prio_if_inst got %h want %h", if_done_inst, if_q[0]);
          void'(if_q.pop_front());
        end else begin
          void'(if_q.pop_front());
        end
        if_req_flag = 1'b0;
      end else begin
        n_vec++;
        if ({lsb_done_flag, if_done_flag} !== 2'b00) begin
          n_bad++;
          $display("FAIL prio_stray c%0d got lsb/if=%b%b want 00", c, lsb_done_flag, if_done_flag);
        end
      end
    end
  endtask

  task automatic test_flush();
    // fetch killed in cycle 2
    if_req_flag = 1'b1;
    if_req_addr = 32'h400;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 2) begin
        jump_wrong_stall = 1'b1;
        if_req_flag      = 1'b0;
      end else begin
        jump_wrong_stall = 1'b0;
      end
      n_vec++;
      if ({if_done_flag, mem_wr} !== 2'b00) begin
        n_bad++; $display("FAIL flush_abort c%0d got if_done/wr=%b%b want 00", c, if_done_flag,
                          mem_wr);
      end
    end
    // stall in IDLE swallows that cycle's fetch request
    if_q.push_back(32'h00A0_0513);
    if_req_flag      = 1'b1;
    jump_wrong_stall = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      jump_wrong_stall = 1'b0;
      if (c == 7) begin
        n_vec++;
        if (if_done_flag !== 1'b1 || if_q.size() == 0) begin
          n_bad++; $display("FAIL flush_idle_done got %b want 1", if_done_flag);
        end else begin
          if (if_done_inst !== if_q[0]) begin
            n_bad++; $display("FAIL flush_idle_inst got %h want %h", if_done_inst, if_q[0]);
          end
          void'(if_q.pop_front());
        end
        if_req_flag = 1'b0;
      end else begin
        n_vec++;
        if (if_done_flag !== 1'b0) begin
          n_bad++; $display("FAIL flush_idle_early c%0d got %b want 0", c, if_done_flag);
        end
      end
    end
  endtask

  task automatic test_cdb_suppress();
    lsb_req_flag   = 1'b1;
    lsb_req_width  = 2'b00;
    lsb_req_type   = 1'b0;
    lsb_req_sext   = 1'b1;
    lsb_req_addr   = 32'h200;
    lsb_req_rob_id = 32'h5;
    for (int c = 1; c <= 4; c++) begin
      step();
      lsb_req_flag     = 1'b0;
      jump_wrong_stall = (c == 2);
      if (c == 3) begin
        n_vec++;
        if ({lsb_done_flag, ld_cdb_flag} !== 2'b10) begin
          n_bad++; $display("FAIL cdb_suppress got %b%b want 10", lsb_done_flag, ld_cdb_flag);
        end
      end else begin
        n_vec++;
        if ({lsb_done_flag, ld_cdb_flag} !== 2'b00) begin
          n_bad++;
          $display("FAIL cdb_suppress_stray c%0d got %b%b want 00", c, lsb_done_flag, ld_cdb_flag);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    lsb_req_flag   = 1'b1;
    lsb_req_width  = 2'b11;
    lsb_req_type   = 1'b0;
    lsb_req_addr   = 32'h100;
    lsb_req_rob_id = 32'h9;
    repeat (3) begin
      step();
      lsb_req_flag = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({mem_a, mem_wr, lsb_done_flag, ld_cdb_flag, ld_cdb_val, ld_cdb_rob_id} !== 99'd0) begin
      n_bad++;
      $display("FAIL reset_mid got a=%h wr=%b done=%b cdb=%b val=%h tag=%h want all 0", mem_a,
               mem_wr, lsb_done_flag, ld_cdb_flag, ld_cdb_val, ld_cdb_rob_id);
    end
    step();
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_vec++;
      if ({lsb_done_flag, ld_cdb_flag, mem_wr, mem_a} !== 35'd0) begin
        n_bad++;
        $display("FAIL reset_mid_after c%0d got done=%b cdb=%b wr=%b a=%h want 0", c,
                 lsb_done_flag, ld_cdb_flag, mem_wr, mem_a);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) init_mem[i] = 8'h00;
    init_mem[12'h100] = 8'h78; init_mem[12'h101] = 8'h56;
    init_mem[12'h102] = 8'h34; init_mem[12'h103] = 8'h12;
    init_mem[12'h200] = 8'h80;
    init_mem[12'h210] = 8'h01; init_mem[12'h211] = 8'h80;
    init_mem[12'h400] = 8'h13; init_mem[12'h401] = 8'h05;
    init_mem[12'h402] = 8'hA0; init_mem[12'h403] = 8'h00;
    init_mem[12'hFFE] = 8'hEF; init_mem[12'hFFF] = 8'hBE;
    init_mem[12'h000] = 8'hAD; init_mem[12'h001] = 8'hDE;

    test_reset();
    test_load("lw", 32'h100, 2'b11, 1'b0, 32'h2A, 32'h1234_5678);
    test_load("lb", 32'h200, 2'b00, 1'b1, 32'h11, 32'hFFFF_FF80);
    test_load("lbu", 32'h200, 2'b00, 1'b0, 32'h12, 32'h0000_0080);
    test_load("lh", 32'h210, 2'b01, 1'b1, 32'h13, 32'hFFFF_8001);
    test_load("lhu", 32'h210, 2'b01, 1'b0, 32'h14, 32'h0000_8001);
    test_load("lw_wrap", 32'hFFFF_FFFE, 2'b11, 1'b0, 32'h15, 32'hDEAD_BEEF);
    test_store("sh", 32'h300, 2'b01, 32'hAABB_CCDD, 0);
    test_store("sw_rdy", 32'h500, 2'b11, 32'h1122_3344, 2);
    test_priority();
    test_flush();
    test_cdb_suppress();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port, byte-serial RAM arbiter sitting directly downstream of the load/store buffer and the instruction fetcher.
- Serialises 1/2/4-byte LSB loads and stores and 4-byte instruction fetches onto an 8-bit RAM bus.
- On completion it pulses lsb_done_flag and if_done_flag.
- It also broadcasts load results on the load CDB (ld_cdb_*).

Parameters:
IO_BASE, 32'h0003_0000, addresses >= IO_BASE are the IO region (used only by the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low freezes all state and outputs
mem_din  in  8  RAM read byte, valid the cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full
if_req_flag  in  1  fetch request, level, held until if_done_flag
if_req_addr  in  32  fetch address
if_done_flag  out  1  one-cycle pulse, instruction valid
if_done_inst  out  32  fetched word, little-endian
jump_wrong_stall  in  1  mispredict flush
lsb_req_flag  in  1  LSB request; may repeat every cycle for the same head
lsb_req_width  in  2  00 = byte, 01 = half, 11 = word
lsb_req_type  in  1  0 = load, 1 = store
lsb_req_sext  in  1  1 = sign-extend load result (LB/LH)
lsb_req_addr  in  32  byte address
lsb_req_data  in  32  store data, low bytes used
lsb_req_rob_id  in  32  ROB tag
lsb_done_flag  out  1  one-cycle pulse, LSB op finished
ld_cdb_flag  out  1  load result broadcast pulse
ld_cdb_rob_id  out  32  tag of the broadcast load
ld_cdb_val  out  32  extended load value

Behaviour:
- Reset (rst low, async): state = IDLE, counters = 0. All outputs 0: mem_a, mem_dout, mem_wr, if_done_*, lsb_done_flag, ld_cdb_*. Reset mid-transfer aborts it silently.
- rdy low: every register holds its value, including mem_wr and the counters.
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
  - IDLE + lsb_req_flag: latch all lsb_req_* fields, n = 1/2/4 from width. Go to LS_RD or LS_WR.
  - IDLE + if_req_flag without lsb_req_flag: latch the address, n = 4, go to IF_RD. The LSB has priority.
- Cycle numbering: cycle 0 = the IDLE cycle in which the request is sampled.
- Read (LS_RD/IF_RD):
  - Cycles 1..n: mem_a = addr + k (k = 0..n-1), mem_wr = 0.
  - Byte k is captured from mem_din in cycle k+2.
  - The done pulse is registered and high in cycle n+2 (LW: cycle 6, LB: cycle 3).
- Write (LS_WR):
  - Cycles 1..n: mem_wr = 1, mem_a = addr + k, mem_dout = data[8k+7:8k].
  - lsb_done_flag is high in cycle n+1; ld_cdb_flag stays 0.
  - mem_wr returns to 0 in cycle n+1.
- Assembly: bytes are little-endian.
  - Half/byte loads: sign-extend from bit 15/7 if lsb_req_sext = 1, else zero-extend.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
- DONE (one cycle, holds the done pulses):
  - Load done: lsb_done_flag = 1, ld_cdb_flag = 1, ld_cdb_rob_id = latched tag, ld_cdb_val = assembled value.
  - Store done: lsb_done_flag only.
  - Fetch done: if_done_flag = 1, if_done_inst = assembled word.
  - lsb_req_flag is ignored in DONE, because that pulse refers to the entry being popped.
  - DONE -> IDLE. Every pulse lasts exactly one cycle.
- jump_wrong_stall:
  - In IF_RD: the fetch is abandoned, next state IDLE, no if_done_flag, mem_wr stays 0.
  - Sampled in IDLE: if_req_flag is ignored that cycle.
  - LSB operations are never aborted. lsb_done_flag still pulses, but ld_cdb_flag is suppressed if jump_wrong_stall is high at the edge that enters DONE.
- Only one transaction is ever in flight.

Optional Feature:
- MEMCTRL_IO_GUARD_EN defined:
  - Before each byte of an LS_WR with addr >= IO_BASE: while io_buffer_full = 1, hold mem_wr = 0 and keep the byte counter.
  - After each IO byte write, insert one idle cycle (mem_wr = 0).
  - Write latency stretches accordingly.
- Not defined: io_buffer_full is ignored and IO writes follow normal write timing.

Test Plan:
- LW at 0x100, RAM bytes 0x78, 0x56, 0x34, 0x12 -> mem_a 0x100..0x103 in cycles 1-4; ld_cdb_val = 0x12345678 with tag, lsb_done_flag + ld_cdb_flag in cycle 6 only.
- LB sext = 1 at 0x200 = 0x80 -> ld_cdb_val = 0xFFFFFF80. LBU (sext = 0) -> 0x00000080. Done in cycle 3.
- SH data 0xAABBCCDD at 0x300 -> mem_wr = 1, (0x300, 0xDD), (0x301, 0xCC) in cycles 1-2; lsb_done_flag in cycle 3; ld_cdb_flag stays 0.
- if_req_flag and lsb_req_flag high together in IDLE -> LSB served first. Fetch starts after DONE; repeated lsb_req_flag in DONE is not re-accepted.
- Fetch in progress, jump_wrong_stall in cycle 2 -> IDLE next cycle, no if_done_flag. rst pulled low mid-LW -> all outputs 0 immediately.
- With MEMCTRL_IO_GUARD_EN: SB to 0x30000 while io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 until full drops, then one write; done follows.
